multicycle_ctrl: RTL and testbench

Multi-cycle control unit sequencing the 64-bit RISC-V datapath (PC register/mux, instruction memory, register file, ALU operand mux, data memory). Walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath control lines each state needs: PC write/select, IR load, register-file write enable, ALU source/op, memory request and write-back select. Instruction and data memory accesses use a req/ack handshake, so memories of any latency can be attached.

---
 rtl/multicycle_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control unit for a 64-bit RISC-V datapath.
// Each instruction steps through FETCH, DECODE, EXEC, MEM and WB; this block
// drives the datapath strobes for each state. Memories use req/ack handshakes.
//
// Ports:
//   clk, reset (async, active-low)
//   opcode/funct3/funct7b5 : IR fields
//   alu_zero               : ALU zero flag (branch resolution)
//   imem_ack, dmem_ack     : memory handshake acks
//   imem_req, ir_we        : fetch request / IR load
//   pc_we, pc_select       : PC load / PC mux (0 = PC+inc, 1 = PC+imm<<1)
//   wr_en, mem_to_reg      : register-file write / write-back source
//   alu_src2_sel, alu_ctrl : ALU operand 2 select / ALU operation
//   dmem_req, dmem_we      : data memory request / store
//   illegal                : sticky illegal-instruction flag (HALT)
//   cycle_cnt, instret_cnt : performance counters
//
// Build option: define MCTRL_PERF_CNT_EN to build the performance counters;
// otherwise both counter outputs are tied to 0.

module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        alu_zero,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_select,
  output logic        wr_en,
  output logic        alu_src2_sel,
  output logic [3:0]  alu_ctrl,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluXor = 4'b0011;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  state_e state_q, state_d;

  // Instruction class, decoded straight from the IR fields (IR is stable
  // from DECODE until the instruction retires).
  logic is_r, is_i, is_ld, is_sd, is_br;
  logic alu_f3_ok, legal;
  logic [3:0] alu_op;

  always_comb begin
    is_r  = (opcode == 7'b0110011);
    is_i  = (opcode == 7'b0010011);
    is_ld = (opcode == 7'b0000011);
    is_sd = (opcode == 7'b0100011);
    is_br = (opcode == 7'b1100011);

    alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                (funct3 == 3'b110) || (funct3 == 3'b100);

    legal = ((is_r || is_i) && alu_f3_ok) || is_ld || is_sd ||
            (is_br && (funct3 == 3'b000 || funct3 == 3'b001));

    alu_op = AluAdd;
    if (is_br) begin
      alu_op = AluSub;
    end else if (is_r || is_i) begin
      case (funct3)
        3'b000:  alu_op = (is_r && funct7b5) ? AluSub : AluAdd;
        3'b111:  alu_op = AluAnd;
        3'b110:  alu_op = AluOr;
        3'b100:  alu_op = AluXor;
        default: alu_op = AluAdd;
      endcase
    end
  end

  // Next state and Moore/Mealy strobes; every strobe defaults to 0.
  always_comb begin
    state_d      = state_q;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_select    = 1'b0;
    wr_en        = 1'b0;
    alu_src2_sel = 1'b0;
    alu_ctrl     = AluAdd;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    mem_to_reg   = 1'b0;
    illegal      = 1'b0;

    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = legal ? StExec : StHalt;
      end
      StExec: begin
        alu_ctrl     = alu_op;
        alu_src2_sel = is_i || is_ld || is_sd;
        if (is_br) begin
          pc_we     = 1'b1;
          // funct3[0] distinguishes BNE from BEQ.
          pc_select = funct3[0] ? !alu_zero : alu_zero;
          state_d   = StFetch;
        end else if (is_ld || is_sd) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        alu_ctrl     = alu_op;
        alu_src2_sel = 1'b1;
        dmem_req     = 1'b1;
        dmem_we      = is_sd;
        if (dmem_ack) begin
          if (is_sd) begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        alu_ctrl     = alu_op;
        alu_src2_sel = is_i || is_ld;
        wr_en        = 1'b1;
        mem_to_reg   = is_ld;
        pc_we        = 1'b1;
        state_d      = StFetch;
      end
      StHalt: begin
        illegal = 1'b1;
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef MCTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  // pc_we fires exactly once per instruction, in its final cycle.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + 32'd1;
    instret_cnt_d = instret_cnt_q + {31'd0, pc_we};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q   <= 32'd0;
      instret_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Strobe vector bit order:
// [9]imem_req [8]ir_we [7]pc_we [6]pc_select [5]wr_en [4]alu_src2_sel
// [3]dmem_req [2]dmem_we [1]mem_to_reg [0]illegal

module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        funct7b5 = 1'b0;
  logic        alu_zero = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        imem_req, ir_we, pc_we, pc_select, wr_en, alu_src2_sel;
  logic [3:0]  alu_ctrl;
  logic        dmem_req, dmem_we, mem_to_reg, illegal;
  logic [31:0] cycle_cnt, instret_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  multicycle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7b5     (funct7b5),
    .alu_zero     (alu_zero),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_select    (pc_select),
    .wr_en        (wr_en),
    .alu_src2_sel (alu_src2_sel),
    .alu_ctrl     (alu_ctrl),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .mem_to_reg   (mem_to_reg),
    .illegal      (illegal),
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OpR  = 7'b0110011;
  localparam logic [6:0] OpI  = 7'b0010011;
  localparam logic [6:0] OpLd = 7'b0000011;
  localparam logic [6:0] OpSd = 7'b0100011;
  localparam logic [6:0] OpBr = 7'b1100011;

  localparam logic [9:0] SNone    = 10'b0000000000;
  localparam logic [9:0] SFetchW  = 10'b1000000000;
  localparam logic [9:0] SFetch   = 10'b1100000000;
  localparam logic [9:0] SWbR     = 10'b0010100000;
  localparam logic [9:0] SWbI     = 10'b0010110000;
  localparam logic [9:0] SWbLd    = 10'b0010110010;
  localparam logic [9:0] SExecMem = 10'b0000010000;
  localparam logic [9:0] SMemLd   = 10'b0000011000;
  localparam logic [9:0] SMemSd   = 10'b0000011100;
  localparam logic [9:0] SMemSdAk = 10'b0010011100;
  localparam logic [9:0] SBrTaken = 10'b0011000000;
  localparam logic [9:0] SBrNot   = 10'b0010000000;
  localparam logic [9:0] SHalt    = 10'b0000000001;

  function automatic logic [9:0] strobes();
    return {imem_req, ir_we, pc_we, pc_select, wr_en, alu_src2_sel,
            dmem_req, dmem_we, mem_to_reg, illegal};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
  endtask

  // Drive one cycle's inputs, check the combinational outputs, step to the
  // next edge (returns 1 time unit after it).
  task automatic cyc(input string tag, input logic ia, input logic da, input logic z,
                     input logic [9:0] es, input logic [3:0] ea);
    imem_ack = ia;
    dmem_ack = da;
    alu_zero = z;
    #1;
    check({tag, ".strobes"}, {22'd0, strobes()}, {22'd0, es});
    check({tag, ".alu"}, {28'd0, alu_ctrl}, {28'd0, ea});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst.strobes", {22'd0, strobes()}, {22'd0, SFetchW});
    check("rst.alu", {28'd0, alu_ctrl}, 32'h2);
    check("rst.cycle", cycle_cnt, 32'd0);
    check("rst.instret", instret_cnt, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // R ADD, zero wait; stray dmem_ack in FETCH and imem_ack in EXEC are ignored
    set_instr(OpR, 3'b000, 1'b0);
    cyc("add.fetch", 1, 1, 0, SFetch, 4'b0010);
    cyc("add.dec", 0, 1, 0, SNone, 4'b0010);
    cyc("add.exec", 1, 1, 0, SNone, 4'b0010);
    cyc("add.wb", 0, 0, 0, SWbR, 4'b0010);

    // R SUB with two imem wait cycles
    set_instr(OpR, 3'b000, 1'b1);
    cyc("sub.fetchw0", 0, 0, 0, SFetchW, 4'b0010);
    cyc("sub.fetchw1", 0, 0, 0, SFetchW, 4'b0010);
    cyc("sub.fetch", 1, 0, 0, SFetch, 4'b0010);
    cyc("sub.dec", 0, 0, 0, SNone, 4'b0010);
    cyc("sub.exec", 0, 0, 0, SNone, 4'b0110);
    cyc("sub.wb", 0, 0, 0, SWbR, 4'b0110);

    // R AND, I OR, I XOR
    set_instr(OpR, 3'b111, 1'b0);
    cyc("and.fetch", 1, 0, 0, SFetch, 4'b0010);
    cyc("and.dec", 0, 0, 0, SNone, 4'b0010);
    cyc("and.exec", 0, 0, 0, SNone, 4'b0000);
    cyc("and.wb", 0, 0, 0, SWbR, 4'b0000);
    set_instr(OpI, 3'b110, 1'b1);
    cyc("ori.fetch", 1, 0, 0, SFetch, 4'b0010);
    cyc("ori.dec", 0, 0, 0, SNone, 4'b0010);
    cyc("ori.exec", 0, 0, 0, SExecMem, 4'b0001);
    cyc("ori.wb", 0, 0, 0, SWbI, 4'b0001);
    set_instr(OpI, 3'b100, 1'b0);
    cyc("xori.fetch", 1, 0, 0, SFetch, 4'b0010);
    cyc("xori.dec", 0, 0, 0, SNone, 4'b0010);
    cyc("xori.exec", 0, 0, 0, SExecMem, 4'b0011);
    cyc("xori.wb", 0, 0, 0, SWbI, 4'b0011);

    // LD with dmem_ack delayed 3 cycles: 8 cycles total
    set_instr(OpLd, 3'b011, 1'b0);
    cyc("ld.fetch", 1, 0, 0, SFetch, 4'b0010);
    cyc("ld.dec", 0, 0, 0, SNone, 4'b0010);
    cyc("ld.exec", 0, 0, 0, SExecMem, 4'b0010);
    for (int i = 0; i < 3; i++) cyc("ld.memw", 0, 0, 0, SMemLd, 4'b0010);
    cyc("ld.mem", 0, 1, 0, SMemLd, 4'b0010);
    cyc("ld.wb", 0, 0, 0, SWbLd, 4'b0010);

    // SD zero wait: 4 cycles
    set_instr(OpSd, 3'b011, 1'b0);
    cyc("sd.fetch", 1, 0, 0, SFetch, 4'b0010);
    cyc("sd.dec", 0, 0, 0, SNone, 4'b0010);
    cyc("sd.exec", 0, 0, 0, SExecMem, 4'b0010);
    cyc("sd.mem", 0, 1, 0, SMemSdAk, 4'b0010);

    // BEQ taken, BNE not taken (alu_zero=1), BNE taken (alu_zero=0)
    set_instr(OpBr, 3'b000, 1'b0);
    cyc("beq.fetch", 1, 0, 1, SFetch, 4'b0010);
    cyc("beq.dec", 0, 0, 1, SNone, 4'b0010);
    cyc("beq.exec", 0, 0, 1, SBrTaken, 4'b0110);
    set_instr(OpBr, 3'b001, 1'b0);
    cyc("bne.fetch", 1, 0, 1, SFetch, 4'b0010);
    cyc("bne.dec", 0, 0, 1, SNone, 4'b0010);
    cyc("bne.exec", 0, 0, 1, SBrNot, 4'b0110);
    cyc("bne2.fetch", 1, 0, 0, SFetch, 4'b0010);
    cyc("bne2.dec", 0, 0, 0, SNone, 4'b0010);
    cyc("bne2.exec", 0, 0, 0, SBrTaken, 4'b0110);

    // Reset mid-MEM of an SD: request drops asynchronously, no pc_we
    set_instr(OpSd, 3'b011, 1'b0);
    cyc("sdr.fetch", 1, 0, 0, SFetch, 4'b0010);
    cyc("sdr.dec", 0, 0, 0, SNone, 4'b0010);
    cyc("sdr.exec", 0, 0, 0, SExecMem, 4'b0010);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    check("sdr.mem", {22'd0, strobes()}, {22'd0, SMemSd});
    #1;
    reset = 1'b0;
    dmem_ack = 1'b1;
    #1;
    check("sdr.inreset", {22'd0, strobes()}, {22'd0, SFetchW});
    @(posedge clk);
    #1;
    check("sdr.heldreset", {22'd0, strobes()}, {22'd0, SFetchW});
    reset = 1'b1;
    cyc("sdr.after", 0, 1, 0, SFetchW, 4'b0010);
    cyc("sdr.after2", 0, 0, 0, SFetchW, 4'b0010);

    // Illegal opcode: HALT held through imem_ack toggling
    set_instr(7'b1111111, 3'b000, 1'b0);
    cyc("ill.fetch", 1, 0, 0, SFetch, 4'b0010);
    cyc("ill.dec", 0, 0, 0, SNone, 4'b0010);
    for (int i = 0; i < 10; i++) cyc("ill.halt", i[0], 0, 0, SHalt, 4'b0010);

    // Unsupported funct3 on an R-type also halts
    do_reset();
    set_instr(OpR, 3'b001, 1'b0);
    cyc("illf.fetch", 1, 0, 0, SFetch, 4'b0010);
    cyc("illf.dec", 0, 0, 0, SNone, 4'b0010);
    cyc("illf.halt", 1, 1, 0, SHalt, 4'b0010);

    // Counters: 2 ADD + 1 BEQ at zero wait = 11 cycles, 3 retires
    do_reset();
    for (int n = 0; n < 2; n++) begin
      set_instr(OpR, 3'b000, 1'b0);
      cyc("cnt.add.fetch", 1, 0, 0, SFetch, 4'b0010);
      cyc("cnt.add.dec", 0, 0, 0, SNone, 4'b0010);
      cyc("cnt.add.exec", 0, 0, 0, SNone, 4'b0010);
      cyc("cnt.add.wb", 0, 0, 0, SWbR, 4'b0010);
    end
    set_instr(OpBr, 3'b000, 1'b0);
    cyc("cnt.beq.fetch", 1, 0, 1, SFetch, 4'b0010);
    cyc("cnt.beq.dec", 0, 0, 1, SNone, 4'b0010);
    cyc("cnt.beq.exec", 0, 0, 1, SBrTaken, 4'b0110);
`ifdef MCTRL_PERF_CNT_EN
    check("cnt.cycle", cycle_cnt, 32'd11);
    check("cnt.instret", instret_cnt, 32'd3);
    force dut.instret_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_cnt_q;
    check("cnt.preload", instret_cnt, 32'hFFFF_FFFF);
    cyc("wrap.fetch", 1, 0, 1, SFetch, 4'b0010);
    cyc("wrap.dec", 0, 0, 1, SNone, 4'b0010);
    check("wrap.before", instret_cnt, 32'hFFFF_FFFF);
    cyc("wrap.exec", 0, 0, 1, SBrTaken, 4'b0110);
    check("wrap.instret", instret_cnt, 32'd0);
`else
    check("cnt.cycle.off", cycle_cnt, 32'd0);
    check("cnt.instret.off", instret_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
